i2c_req_sched: RTL

//  Shares one byte-oriented I2C master engine between N independent requesters
//  (redriver config sequencer, readback/monitor, debug port). Round-robin arbitration,
//  one transaction at a time, NACK retry, watchdog timeout. Returns per-requester

---
 rtl/i2c_ctrl_pkg.sv | 30 +++
 rtl/rr_arbiter_n.sv | 42 ++++
 rtl/i2c_req_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/i2c_ctrl_pkg.sv
// rtl/i2c_ctrl_pkg.sv - shared encodings and helpers for the I2C request scheduler
//
// Purpose: FSM state encodings, read/write encoding, latched command layout
//          and a counter-width helper used by the scheduler and its arbiter.
// Ports:   none (package).
package i2c_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] offset;
    logic [7:0] wdata;
  } cmd_t;

  // Bits needed to hold values 0..maxCount-1, never less than one bit.
  function automatic int ctrWidth(input int maxCount);
    return (maxCount <= 2) ? 1 : $clog2(maxCount);
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - combinational round-robin one-hot winner selection
//
// Purpose: returns the first set request bit at or after ivPtr+1, wrapping
//          modulo N_REQ. ovGnt is all-zero when no request is set.
// Ports:
//   ivReq  in  N_REQ  request vector
//   ivPtr  in  IDX_W  index of the most recently served requester
//   ovGnt  out N_REQ  one-hot winner
module rr_arbiter_n
  import i2c_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = ctrWidth(N_REQ)
) (
  input  logic [N_REQ-1:0] ivReq,
  input  logic [IDX_W-1:0] ivPtr,
  output logic [N_REQ-1:0] ovGnt
);

  // One extra bit so ptr+k (at most 2*N_REQ-1) never overflows before the wrap.
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] pos;
  logic             found;

  always_comb begin
    ovGnt = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = {1'b0, ivPtr} + SUM_W'(k);
      if (pos >= SUM_W'(N_REQ)) begin
        pos = pos - SUM_W'(N_REQ);
      end
      if (!found && ivReq[pos[IDX_W-1:0]]) begin
        ovGnt[pos[IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_sched.sv
// rtl/i2c_req_sched.sv - round-robin scheduler sharing one I2C master among N requesters
//
// Purpose: grants one requester at a time, latches its command, strobes the
//          master engine, retries on NACK after a gap, aborts on watchdog
//          timeout and returns a per-requester done pulse with error flag.
// Ports:
//   iClk, iRstn                  clock, async active-low reset
//   ivReq/ivRW                   per-requester level request and direction
//   ivAddr/ivOffset/ivWData      per-requester packed command fields
//   ovGnt                        one-hot grant held for the whole transaction
//   ovDone/oErr/ovRData          completion pulse, error flag, last good read byte
//   oMstStart/oMstRW/ovMstAddr/ovMstOffset/ovMstWData  command to master engine
//   iMstBusy/iMstDone/iMstNack/ivMstRData               status from master engine
module i2c_req_sched
  import i2c_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MAX_RETRY   = 3,
  parameter int RETRY_GAP   = 256,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               iClk,
  input  logic               iRstn,
  input  logic [N_REQ-1:0]   ivReq,
  input  logic [N_REQ-1:0]   ivRW,
  input  logic [N_REQ*7-1:0] ivAddr,
  input  logic [N_REQ*8-1:0] ivOffset,
  input  logic [N_REQ*8-1:0] ivWData,
  output logic [N_REQ-1:0]   ovGnt,
  output logic [N_REQ-1:0]   ovDone,
  output logic               oErr,
  output logic [7:0]         ovRData,
  output logic               oMstStart,
  output logic               oMstRW,
  output logic [7:0]         ovMstAddr,
  output logic [7:0]         ovMstOffset,
  output logic [7:0]         ovMstWData,
  input  logic               iMstBusy,
  input  logic               iMstDone,
  input  logic               iMstNack,
  input  logic [7:0]         ivMstRData
);

  localparam int IDX_W = ctrWidth(N_REQ);
  localparam int RTY_W = ctrWidth(MAX_RETRY + 1);
  localparam int GAP_W = ctrWidth(RETRY_GAP);
  localparam int TO_W  = ctrWidth(TIMEOUT_CYC);

  logic [2:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gntIdx;
  logic [RTY_W-1:0] retryCnt;
  logic [GAP_W-1:0] gapCnt;
  logic [TO_W-1:0]  toCnt;
  logic [N_REQ-1:0] arbGnt;
  cmd_t             selCmd;

  function automatic logic [IDX_W-1:0] oneHotIdx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  rr_arbiter_n #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) uArb (
    .ivReq (ivReq),
    .ivPtr (ptr),
    .ovGnt (arbGnt)
  );

  // Granted requester's fields, sampled only in LATCH.
  always_comb begin
    selCmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gntIdx == IDX_W'(i)) begin
        selCmd.rw     = ivRW[i];
        selCmd.addr   = ivAddr[7*i +: 7];
        selCmd.offset = ivOffset[8*i +: 8];
        selCmd.wdata  = ivWData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      gntIdx      <= '0;
      retryCnt    <= '0;
      gapCnt      <= '0;
      toCnt       <= '0;
      ovGnt       <= '0;
      ovDone      <= '0;
      oErr        <= 1'b0;
      ovRData     <= '0;
      oMstStart   <= 1'b0;
      oMstRW      <= 1'b0;
      ovMstAddr   <= '0;
      ovMstOffset <= '0;
      ovMstWData  <= '0;
    end else begin
      oMstStart <= 1'b0;
      ovDone    <= '0;
      oErr      <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A master still busy after a timeout must finish before the next grant.
          if (|ivReq && !iMstBusy) begin
            ovGnt  <= arbGnt;
            gntIdx <= oneHotIdx(arbGnt);
            state  <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          oMstRW      <= selCmd.rw;
          ovMstAddr   <= {selCmd.addr, selCmd.rw};
          ovMstOffset <= selCmd.offset;
          ovMstWData  <= selCmd.wdata;
          retryCnt    <= '0;
          state       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          oMstStart <= 1'b1;
          toCnt     <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the final timeout cycle takes precedence.
          if (iMstDone) begin
            if (!iMstNack) begin
              ovDone <= ovGnt;
              if (oMstRW == RW_READ) begin
                ovRData <= ivMstRData;
              end
              state <= ST_RESP;
            end else if (retryCnt < RTY_W'(MAX_RETRY)) begin
              retryCnt <= retryCnt + RTY_W'(1);
              gapCnt   <= '0;
              state    <= ST_GAP;
            end else begin
              ovDone <= ovGnt;
              oErr   <= 1'b1;
              state  <= ST_RESP;
            end
          end else if (toCnt == TO_W'(TIMEOUT_CYC - 1)) begin
            ovDone <= ovGnt;
            oErr   <= 1'b1;
            state  <= ST_RESP;
          end else begin
            toCnt <= toCnt + TO_W'(1);
          end
        end
        ST_GAP: begin
          if (gapCnt == GAP_W'(RETRY_GAP - 1)) begin
            state <= ST_ISSUE;
          end else begin
            gapCnt <= gapCnt + GAP_W'(1);
          end
        end
        ST_RESP: begin
          ptr   <= gntIdx;
          ovGnt <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
